// File: rtl/dequant.sv
// Affine dequantizer: odata = sat(round((idata - zero_point) * scale >>> shift)).
// Ports: clock/reset, in_valid/in_ready + idata/zero_point/scale/shift, out_valid/out_ready + odata/sat.
module dequant #(
  parameter int IN_W    = 8,
  parameter int SCALE_W = 16,
  parameter int SHIFT_W = 4,
  parameter int OUT_W   = 18
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [IN_W-1:0]           idata,
  input  logic [IN_W-1:0]           zero_point,
  input  logic signed [SCALE_W-1:0] scale,
  input  logic [SHIFT_W-1:0]        shift,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [OUT_W-1:0]   odata,
  output logic                      sat
);

  localparam int DW = IN_W + 1;
  localparam int PW = DW + SCALE_W;
  localparam int RW = PW + 1;

  localparam logic signed [RW-1:0] MAX_V =
    RW'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [RW-1:0] MIN_V = ~MAX_V;

  logic en;

  logic                      v1;
  logic signed [DW-1:0]      d1;
  logic signed [SCALE_W-1:0] sc1;
  logic [SHIFT_W-1:0]        sh1;

  logic                      v2;
  logic signed [PW-1:0]      p2;
  logic [SHIFT_W-1:0]        sh2;

  logic signed [DW-1:0]      d_c;
  logic signed [PW-1:0]      p_c;
  logic signed [RW-1:0]      sum_c;
  logic signed [RW-1:0]      r_c;
  logic signed [OUT_W-1:0]   o_c;
  logic                      sat_c;

  // Whole pipe moves as one; bubbles advance like data.
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  assign d_c = $signed({1'b0, idata}) - $signed({1'b0, zero_point});
  assign p_c = PW'(d1) * PW'(sc1);

  // Round half toward +inf, then clamp to the output range.
  always_comb begin
    sum_c = RW'(p2);
    if (sh2 != '0)
      sum_c = RW'(p2) + (RW'(1) <<< (sh2 - SHIFT_W'(1)));
    r_c   = sum_c >>> sh2;
    sat_c = 1'b0;
    o_c   = r_c[OUT_W-1:0];
    if (r_c > MAX_V) begin
      sat_c = 1'b1;
      o_c   = MAX_V[OUT_W-1:0];
    end else if (r_c < MIN_V) begin
      sat_c = 1'b1;
      o_c   = MIN_V[OUT_W-1:0];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      v1        <= 1'b0;
      d1        <= '0;
      sc1       <= '0;
      sh1       <= '0;
      v2        <= 1'b0;
      p2        <= '0;
      sh2       <= '0;
      out_valid <= 1'b0;
      odata     <= '0;
      sat       <= 1'b0;
    end else if (en) begin
      v1 <= in_valid;
      if (in_valid) begin
        d1  <= d_c;
        sc1 <= scale;
        sh1 <= shift;
      end
      v2 <= v1;
      if (v1) begin
        p2  <= p_c;
        sh2 <= sh1;
      end
      out_valid <= v2;
      // Output keeps its last value across bubbles.
      if (v2) begin
        odata <= o_c;
        sat   <= sat_c;
      end
    end
  end

endmodule
